// File: rtl/mem_stage_ctrl_if.sv
// MEM stage request bus between the EXE/MEM register and the data-memory
// controller: read/write enables, byte address, store data, load result, ready.
interface mem_stage_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage data-memory controller: splits each 32-bit access into two 16-bit
// SRAM phases with wait states. Optional read-hit shortcut: MEM_CTRL_READ_HIT_EN.
module mem_stage_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3,
    parameter int SRAM_AW     = 18
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mem_stage_ctrl_if.slave    bus,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [15:0]        o_sram_wdata,
    input  logic [15:0]        i_sram_rdata,
    output logic               o_sram_we_n,
    output logic               o_sram_oe_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE = 32'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]      r_cnt;
    logic [31:0]        r_read_data;
    logic [SRAM_AW-1:0] r_addr_hold;
    logic [15:0]        r_wdata_hold;

    logic [31:0]        w_diff;
    logic [SRAM_AW-2:0] w_word;
    logic               w_phase;
    logic               w_last;
    logic               w_ready;
    logic               w_hit;
    logic               w_unused;

    // Halfword address: low half at even SRAM address, high half at odd.
    assign w_diff   = bus.address - BASE;
    assign w_word   = w_diff[SRAM_AW:2];
    assign w_unused = ^{w_diff[31:SRAM_AW+1], w_diff[1:0]};

    assign w_phase = (r_state == S_WR_LO) || (r_state == S_WR_HI) ||
                     (r_state == S_RD_LO) || (r_state == S_RD_HI);
    assign w_last  = w_phase && (r_cnt == LAST);

`ifdef MEM_CTRL_READ_HIT_EN
    logic [SRAM_AW-2:0] r_last_word;
    logic               r_hit_valid;

    assign w_hit = r_hit_valid && (w_word == r_last_word);

    // Remember the last completed read word; any write invalidates it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hit_valid <= 1'b0;
            r_last_word <= '0;
        end else if (r_state == S_IDLE && bus.wr_en) begin
            r_hit_valid <= 1'b0;
        end else if (r_state == S_RD_HI && w_last) begin
            r_hit_valid <= 1'b1;
            r_last_word <= w_word;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and ready; write wins over read in IDLE.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = ~(bus.rd_en | bus.wr_en);
                if (bus.wr_en)      w_next = S_WR_LO;
                else if (bus.rd_en) w_next = w_hit ? S_DONE : S_RD_LO;
            end
            S_WR_LO: if (w_last) w_next = S_WR_HI;
            S_WR_HI: if (w_last) w_next = S_DONE;
            S_RD_LO: if (w_last) w_next = S_RD_HI;
            S_RD_HI: if (w_last) w_next = S_DONE;
            S_DONE: begin
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // SRAM pins follow the phase; address/data hold outside phases.
    always_comb begin
        o_sram_addr  = r_addr_hold;
        o_sram_wdata = r_wdata_hold;
        o_sram_we_n  = 1'b1;
        o_sram_oe_n  = 1'b1;
        unique case (1'b1)
            (r_state == S_WR_LO): begin
                o_sram_addr  = {w_word, 1'b0};
                o_sram_wdata = bus.write_data[15:0];
                o_sram_we_n  = 1'b0;
            end
            (r_state == S_WR_HI): begin
                o_sram_addr  = {w_word, 1'b1};
                o_sram_wdata = bus.write_data[31:16];
                o_sram_we_n  = 1'b0;
            end
            (r_state == S_RD_LO): begin
                o_sram_addr = {w_word, 1'b0};
                o_sram_oe_n = 1'b0;
            end
            (r_state == S_RD_HI): begin
                o_sram_addr = {w_word, 1'b1};
                o_sram_oe_n = 1'b0;
            end
            default: ;
        endcase
    end

    // Wait counter, hold registers and load-data capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_read_data  <= '0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_addr_hold  <= o_sram_addr;
            r_wdata_hold <= o_sram_wdata;
            if (w_phase && !w_last) r_cnt <= r_cnt + 1'b1;
            else                    r_cnt <= '0;
            if (r_state == S_RD_LO && w_last)
                r_read_data[15:0] <= i_sram_rdata;
            if (r_state == S_RD_HI && w_last)
                r_read_data[31:16] <= i_sram_rdata;
        end
    end

    assign bus.ready     = w_ready;
    assign bus.read_data = r_read_data;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the MEM stage's data-memory access for the EXE/MEM pipeline output: one 32-bit read or write becomes two 16-bit accesses to an external SRAM with programmable wait states.
- Drives `ready`. While `ready` is 0, the pipeline registers are frozen, so address, data and enables stay stable until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3: cycles each 16-bit SRAM phase is held. Must be ≥ 1.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- rd_en  in  1  read request (mem_r_en from the EXE/MEM register)
- wr_en  in  1  write request (mem_w_en from the EXE/MEM register)
- address  in  32  byte address (alu_res from the EXE/MEM register)
- write_data  in  32  store data (val_Rm from the EXE/MEM register)
- read_data  out  32  load result, registered
- ready  out  1  1 = no access pending / access completing; 0 = freeze pipeline
- sram_addr  out  SRAM_AW  SRAM halfword address
- sram_wdata  out  16  SRAM write data
- sram_rdata  in  16  SRAM read data
- sram_we_n  out  1  SRAM write strobe, active-low
- sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
- Reset (rst sampled high at a clock edge):
  - state = IDLE, wait counter = 0, read_data = 0.
  - sram_addr = 0, sram_wdata = 0, sram_we_n = 1, sram_oe_n = 1.
  - rst overrides everything. An in-flight access is aborted; strobes deassert in the cycle after the edge.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- Address mapping:
  - word = (address − BASE_ADDR) >> 2, 32-bit unsigned subtract.
  - LO phase uses sram_addr = {word, 0}; HI phase uses {word, 1}. Both truncated to SRAM_AW.
  - Low halfword lives at the lower SRAM address.
  - address[1:0] is ignored.
- Phase transitions:
  - IDLE: wr_en → WR_LO. Otherwise rd_en → RD_LO. Otherwise stay.
  - If wr_en and rd_en are both high, the write wins and the read is not performed.
  - Each LO/HI phase lasts exactly WAIT_CYCLES cycles; the counter counts 0..WAIT_CYCLES−1 and resets on each phase change.
  - Then LO → HI, and HI → DONE.
  - DONE → IDLE after 1 cycle, unconditionally.
- SRAM signals during phases:
  - WR phases: sram_we_n = 0 for all cycles; sram_wdata = write_data[15:0] (LO) or write_data[31:16] (HI).
  - RD phases: sram_oe_n = 0 for all cycles.
  - sram_rdata is captured on the last cycle of each RD phase (counter == WAIT_CYCLES−1) into read_data[15:0] (LO) or read_data[31:16] (HI).
  - Outside phases: sram_we_n = sram_oe_n = 1; sram_addr and sram_wdata hold their last values.
- `ready` (combinational from state and inputs):
  - IDLE: ready = ~(rd_en | wr_en).
  - WR_*/RD_*: ready = 0.
  - DONE: ready = 1.
- Latency: from the cycle a request is first seen in IDLE, ready is low for 1 + 2·WAIT_CYCLES cycles, then high for exactly 1 cycle (DONE). With WAIT_CYCLES = 3: 7 cycles low.
- read_data becomes valid in DONE and holds until the next read's LO capture overwrites it. Writes never change read_data.
- Requests dropped mid-access are illegal (the pipeline is frozen). The controller completes the access anyway.
- A request held high across DONE starts a new access on the following IDLE cycle. The pipeline has advanced by then, so this is the next instruction.

Optional Feature:
- Macro: MEM_CTRL_READ_HIT_EN.
- Defined:
  - Adds last_word (SRAM_AW−1 bits) and hit_valid registers.
  - A successful read sets last_word = word and hit_valid = 1.
  - Any write, or rst, clears hit_valid.
  - An IDLE read (no wr_en) with hit_valid and word == last_word goes IDLE → DONE directly. No SRAM access; read_data is unchanged; ready is low 1 cycle, then high.
- Undefined: registers absent; every read takes the full sequence.

Test Plan (WAIT_CYCLES = 3, BASE_ADDR = 1024; bench uses a 16-bit SRAM model):
1. Write 0xDEADBEEF to 1024 → ready low 7 cycles. sram_addr = 0 with wdata 0xBEEF for 3 cycles, then sram_addr = 1 with wdata 0xDEAD for 3 cycles. sram_we_n low for 6 cycles. ready high in cycle 7.
2. Then read 1024 → sram_oe_n low for 6 cycles; read_data = 0xDEADBEEF in the ready-high cycle; sram_we_n stays 1.
3. Write 0x12345678 to 1036 → SRAM addresses 6 and 7 written with 0x5678 and 0x1234. A read of 1036 returns 0x12345678.
4. rd_en and wr_en both high, address 1024, write_data 0xCAFEF00D → write sequence only; a later read returns 0xCAFEF00D.
5. rst pulsed during RD_HI → next cycle state IDLE, sram_oe_n = 1, read_data = 0, ready = 1 with no request.
6. MEM_CTRL_READ_HIT_EN defined:
   - Two consecutive reads of 1024 → second has ready low 1 cycle and no oe_n pulse.
   - Write to 1040, then read 1024 → full 7-cycle read.
